// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM encoding and sizing for the SPI flash responder.
package spi_flash_pkg;

    localparam int MEM_DEPTH    = 256;
    localparam int ERASE_CYCLES = 256;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_PROG,
        ST_STATUS,
        ST_IGNORE,
        ST_ERASE
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer for an asynchronous level, plus one-clk rise/fall pulses
// taken from the synchronized copy.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise,
    output logic fall
);

    // [1:0] is the synchronizer, [2] holds the previous synchronized value
    logic [2:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[1:0], d_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign rise =  sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder in front of a 256-byte AND-programmed flash array.
// Status read (05h) exists only when SPI_FLASH_RDSR_EN is defined.
module spi_flash_responder
    import spi_flash_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic ncs,
    input  logic DI_from_host,
    output logic DO_to_host,
    output logic DO_oe,
    output logic busy,
    output logic wel
);

    localparam logic [8:0] ERASE_LAST = 9'(ERASE_CYCLES - 1);

    logic       sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [1:0] di_q, di_d;
    logic       di_s;

    state_e     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] op_q, op_d;
    logic [7:0] tx_q, tx_d;
    logic       se_arm_q, se_arm_d;
    logic       do_q, do_d;
    logic       oe_q, oe_d;
    logic       wel_q, wel_d;
    logic       busy_q, busy_d;
    logic [8:0] erase_cnt_q, erase_cnt_d;

    logic [7:0] mem_q [MEM_DEPTH];
    logic       mem_we;
    logic [7:0] mem_waddr, mem_wdata;
    logic [7:0] rx_byte, tx_byte;

    spi_sync_edge u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge u_ncs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (ncs),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    always_comb di_d = {di_q[0], DI_from_host};
    assign di_s = di_q[1];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        op_d        = op_q;
        tx_d        = tx_q;
        se_arm_d    = se_arm_q;
        do_d        = do_q;
        oe_d        = oe_q;
        wel_d       = wel_q;
        busy_d      = busy_q;
        erase_cnt_d = erase_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = 8'hFF;
        rx_byte     = {shreg_q, di_s};
        tx_byte     = 8'h00;

        // Erase runs off busy rather than the state so status polls are served meanwhile
        if (busy_q) begin
            mem_we    = 1'b1;
            mem_waddr = erase_cnt_q[7:0];
            if (erase_cnt_q == ERASE_LAST) begin
                busy_d      = 1'b0;
                wel_d       = 1'b0;
                erase_cnt_d = '0;
                if (state_q == ST_ERASE) state_d = ST_IDLE;
            end else begin
                erase_cnt_d = erase_cnt_q + 9'd1;
            end
        end

        if (ncs_rise) begin
            if (state_q != ST_ERASE) begin
                state_d = se_arm_q ? ST_ERASE : ST_IDLE;
                if (se_arm_q) begin
                    busy_d      = 1'b1;
                    erase_cnt_d = '0;
                end
                if (op_q == OP_PP) wel_d = 1'b0;
                op_d      = '0;
                se_arm_d  = 1'b0;
                bit_cnt_d = '0;
                oe_d      = 1'b0;
                do_d      = 1'b0;
            end
        end else if (ncs_fall) begin
            if (state_q == ST_IDLE || state_q == ST_ERASE) begin
                state_d   = ST_CMD;
                bit_cnt_d = '0;
            end
        end else if (sclk_rise) begin
            unique case (state_q)
                ST_CMD: begin
                    shreg_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IGNORE;
                        if (!busy_q || rx_byte == OP_RDSR) begin
                            case (rx_byte)
                                OP_READ: begin
                                    op_d    = rx_byte;
                                    state_d = ST_ADDR;
                                end
                                OP_PP, OP_SE: begin
                                    if (wel_q) begin
                                        op_d    = rx_byte;
                                        state_d = ST_ADDR;
                                    end
                                end
                                OP_WREN: wel_d = 1'b1;
                                OP_WRDI: wel_d = 1'b0;
`ifdef SPI_FLASH_RDSR_EN
                                OP_RDSR: state_d = ST_STATUS;
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    shreg_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        addr_d    = rx_byte;
                        case (op_q)
                            OP_READ: state_d = ST_READ;
                            OP_PP:   state_d = ST_PROG;
                            default: begin
                                state_d  = ST_IGNORE;
                                se_arm_d = 1'b1;
                            end
                        endcase
                    end
                end
                ST_PROG: begin
                    shreg_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        mem_we    = 1'b1;
                        mem_waddr = addr_q;
                        mem_wdata = mem_q[addr_q] & rx_byte;
                        addr_d    = addr_q + 8'd1;
                    end
                end
                // Any bit after the SE address disqualifies the erase
                ST_IGNORE: se_arm_d = 1'b0;
                default: ;
            endcase
        end else if (sclk_fall) begin
            if (state_q == ST_READ || state_q == ST_STATUS) begin
                if (bit_cnt_q == 5'd0) begin
                    if (state_q == ST_READ) begin
                        tx_byte = mem_q[addr_q];
                        addr_d  = addr_q + 8'd1;
                    end else begin
                        tx_byte = {6'b0, wel_q, busy_q};
                    end
                    do_d = tx_byte[7];
                    tx_d = {tx_byte[6:0], 1'b0};
                end else begin
                    do_d = tx_q[7];
                    tx_d = {tx_q[6:0], 1'b0};
                end
                oe_d      = 1'b1;
                bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            di_q        <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            op_q        <= '0;
            tx_q        <= '0;
            se_arm_q    <= 1'b0;
            do_q        <= 1'b0;
            oe_q        <= 1'b0;
            wel_q       <= 1'b0;
            busy_q      <= 1'b0;
            erase_cnt_q <= '0;
        end else begin
            di_q        <= di_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            tx_q        <= tx_d;
            se_arm_q    <= se_arm_d;
            do_q        <= do_d;
            oe_q        <= oe_d;
            wel_q       <= wel_d;
            busy_q      <= busy_d;
            erase_cnt_q <= erase_cnt_d;
        end
    end

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign DO_to_host = do_q;
    assign DO_oe      = oe_q;
    assign busy       = busy_q;
    assign wel        = wel_q;

endmodule
